// File: rtl/fetch_queue_if.sv
// Bundle of the instruction-memory request/response port and the decode-side
// instruction port of fetch_queue; master is the fetch unit, slave the environment.
interface fetch_queue_if #(
    parameter int AW = 14
);
    // Handshakes: imem_req/imem_addr are held stable until a cycle with imem_gnt
    // high, after which exactly one imem_rvalid cycle returns the word.
    // Decode side is valid/ready: a word transfers on a rising edge where
    // ir_valid and ir_ready are both high, and ir_valid never waits on ir_ready.
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          ir_valid;
    logic          ir_ready;
    logic [31:0]   ir;
    logic [31:0]   pc_1;

    modport master (
        output imem_req, imem_addr, ir_valid, ir, pc_1,
        input  imem_gnt, imem_rvalid, imem_rdata, ir_ready
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir, pc_1,
        output imem_gnt, imem_rvalid, imem_rdata, ir_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: one-outstanding request FSM feeding a DEPTH-entry
// word queue. Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue #(
    parameter int            DEPTH    = 4,
    parameter int            AW       = 14,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    fetch_queue_if.master bus,
    output logic [1:0]    dbg_state
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          req_q, req_d;
    logic          discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] pc1_mem [DEPTH];
    logic [AW-1:0] next_addr;
    logic          resp;
    logic          push;
    logic          pop;

    // Responses only count in WAIT, so a late word after reset or flush is ignored.
    assign resp      = (state_q == WAIT) && bus.imem_rvalid && !discard_q && !redirect;
    assign pop       = (count_q != '0) && bus.ir_ready && !redirect;
    assign next_addr = addr_q + AW'(1);

`ifdef FETCH_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit   = resp && (count_q == '0);
    assign push         = resp && !(bypass_hit && bus.ir_ready);
    assign bus.ir_valid = (count_q != '0) || bypass_hit;
    assign bus.ir       = (count_q != '0) ? data_mem[rd_ptr_q] : bus.imem_rdata;
    assign bus.pc_1     = (count_q != '0) ? 32'(pc1_mem[rd_ptr_q]) : 32'(next_addr);
`else
    assign push         = resp;
    assign bus.ir_valid = (count_q != '0);
    assign bus.ir       = data_mem[rd_ptr_q];
    assign bus.pc_1     = 32'(pc1_mem[rd_ptr_q]);
`endif

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign dbg_state     = state_q;

    if (AW < 32) begin : g_unused
        logic unused_pc_bits;
        assign unused_pc_bits = ^redirect_pc[31:AW];
    end

    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
        if (redirect) begin
            count_d = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        discard_d  = discard_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc[AW-1:0];
            // A request is still owed a response: wait it out and drop it.
            if ((state_q == WAIT && !bus.imem_rvalid) || (state_q == REQ && bus.imem_gnt)) begin
                state_d   = WAIT;
                req_d     = 1'b0;
                discard_d = 1'b1;
            end else begin
                state_d   = REQ;
                req_d     = 1'b1;
                addr_d    = redirect_pc[AW-1:0];
                discard_d = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q < CW'(DEPTH)) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_q;
                    end
                end
                REQ: begin
                    if (bus.imem_gnt) begin
                        state_d    = WAIT;
                        req_d      = 1'b0;
                        fetch_pc_d = fetch_pc_q + AW'(1);
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        discard_d = 1'b0;
                        if (count_d < CW'(DEPTH)) begin
                            state_d = REQ;
                            req_d   = 1'b1;
                            addr_d  = fetch_pc_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            discard_q  <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            if (redirect) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc1_mem[i]  <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr_q] <= bus.imem_rdata;
            pc1_mem[wr_ptr_q]  <= next_addr;
        end
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front-end for the pipelined `risc_cpu`, sitting directly upstream of the DOF stage. It issues word fetches to an instruction memory that has variable latency over a request/grant/response handshake, and buffers the returned words in a DEPTH-entry queue. It presents each word with its incremented PC (`PC_1`) to decode over a valid/ready handshake. A redirect from the EX-stage PC mux flushes the queue and restarts fetching at the new address; a response already in flight is discarded.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of 2, ≥2
- AW, 14, instruction address width (the PC bits used to index instruction memory)
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- redirect  in  1  one-cycle pulse from EX: discard everything, fetch from redirect_pc
- redirect_pc  in  32  new PC; only bits [AW-1:0] used
- imem_req  out  1  fetch request (registered)
- imem_addr  out  AW  fetch word address (registered)
- imem_gnt  in  1  memory accepted request this cycle
- imem_rvalid  in  1  response data valid this cycle
- imem_rdata  in  32  instruction word
- ir_valid  out  1  ir/pc_1 hold a valid instruction
- ir_ready  in  1  decode consumes this cycle (low = stall)
- ir  out  32  instruction word
- pc_1  out  32  zero-extended (fetch address + 1) mod 2^AW

## Operation
- Reset values: imem_req=0, imem_addr=RESET_PC, ir_valid=0, ir=0, pc_1=0; queue empty, state IDLE, discard=0.
- FSM: IDLE, REQ, WAIT.
  - IDLE→REQ when count + outstanding < DEPTH. imem_req goes high from the next edge; imem_addr = fetch_pc.
  - REQ→WAIT on imem_gnt. fetch_pc += 1, wrapping at 2^AW.
  - WAIT→REQ on imem_rvalid when space remains after the write; otherwise WAIT→IDLE.
- At most one outstanding request.
- While in REQ without gnt, imem_req and imem_addr are held stable. The only exception is the cycle after a redirect, when imem_addr changes to the new PC.
- Response handling: on imem_rvalid with discard=0, push {imem_rdata, addr+1} into the queue. With discard=1, drop the data and clear discard.
- Pop on ir_valid & ir_ready.
- Push and pop in the same cycle are both performed; count is unchanged.
- Redirect has priority over all other events in its cycle:
  - queue cleared; ir_valid=0 from the next edge;
  - fetch_pc ← redirect_pc[AW-1:0];
  - in WAIT, or in REQ with imem_gnt the same cycle: discard←1 and state becomes WAIT;
  - an imem_rvalid in the redirect cycle is dropped;
  - a pop in the redirect cycle is ignored;
  - REQ without gnt: stay in REQ, with the new address from the next edge.
- Full: no new request is issued while count + outstanding = DEPTH.
- Empty: ir_valid=0. ir and pc_1 hold their last values (don't-care).
- Mid-operation reset: all state is cleared asynchronously. An in-flight response arriving after reset is ignored, because outstanding=0 and discard=0 cause rvalid to be ignored outside WAIT.

## Timing
- The first imem_req is high in the first cycle after reset deasserts.
- Minimum fetch latency with the bypass off:
  - gnt at edge N, rvalid at edge N+1;
  - word written at edge N+1;
  - ir_valid high for the cycle after edge N+1.
- Steady-state throughput: one word per (gnt-to-rvalid latency + 1) cycles. Decode sees back-to-back valid words only when the queue has backlog.
- Redirect → first new-PC word on ir: 3 cycles minimum with zero memory wait, 4 cycles if a discarded response is still pending.

## Configuration
- FETCH_BYPASS_EN defined:
  - When the queue is empty and a non-discarded imem_rvalid arrives, ir_valid, ir and pc_1 are driven combinationally from the response in the same cycle.
  - If ir_ready is also high, the word is consumed without being pushed.
  - Saves one cycle of latency.
- FETCH_BYPASS_EN undefined: every word passes through the queue. ir, pc_1 and ir_valid are driven purely from registers.

## Test plan
- Reset release, memory returns rvalid 1 cycle after every gnt, rdata = address, ir_ready=1 → ir sequence 0,1,2,3…; pc_1 = ir+1; no gaps beyond the handshake latency.
- ir_ready=0 for 20 cycles → exactly DEPTH=4 words buffered and imem_req low. Then ir_ready=1 → words 0..3 in order, then fetching resumes at 4.
- Redirect to 0x100 while in WAIT, with the old response arriving 2 cycles later → old word never appears on ir; first ir=0x100 with pc_1=0x101.
- Redirect coincident with imem_rvalid and ir_ready → that word dropped, queue empty next cycle, next imem_addr=redirect_pc.
- Fetch at address 0x3FFF (AW=14) → following imem_addr=0x0000; pc_1 for the 0x3FFF word = 0x0000.
- Reset asserted while in REQ with a pending rvalid → imem_req=0 and ir_valid=0 immediately; the late rvalid is ignored; fetch restarts at RESET_PC.
